mant_mul_seq: RTL and testbench



---
 rtl/mant_mul_seq.sv | 119 +++++++++++
 tb/tb_mant_mul_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mant_mul_seq.sv
// mant_mul_seq
// ----------------------------------------------------------------------------
// Iterative W x W unsigned mantissa multiplier. It processes one partial-
// product row per clock instead of using a W-deep combinational array of rows.
//
// Each RUN cycle the row adds the latched multiplicand into the running
// partial product when the current multiplier bit is set. It then shifts the
// (W+1)-bit row result right by one. The bit that falls out is the row's sum
// bit, and it enters qreg at the MSB. After W rows, {pp, qreg} holds the full
// 2W-bit product.
//
// Handshake: start is a request that is only sampled in IDLE. An accepted
// start moves the block to RUN, and busy stays high until IDLE is re-entered.
// start seen in RUN or DONE is dropped, not queued. done is a one-cycle
// qualifier for product. product holds its value until the next completion.
//
// Ports
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset; aborts any multiply in flight
//   start    : multiply request, sampled in IDLE only
//   a        : multiplicand, captured with an accepted start
//   b        : multiplier, captured with an accepted start, used LSB first
//   busy     : state is not IDLE
//   done     : one-cycle pulse while product is newly valid
//   product  : a*b unsigned, 2W bits
// ----------------------------------------------------------------------------
module mant_mul_seq #(
    parameter int W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   product
);

    localparam int            CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [W-1:0]  mreg;
    logic [W-1:0]  qreg;
    logic [W-1:0]  pp;
    logic [CW-1:0] cnt;

    // Row arithmetic. The sum of two W-bit values fits in W+1 bits, so the
    // result cannot overflow.
    logic [W:0]    t;
    assign t = {1'b0, pp} + (qreg[0] ? {1'b0, mreg} : {(W+1){1'b0}});

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mreg    <= '0;
            qreg    <= '0;
            pp      <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mreg <= a;
                        qreg <= b;
                        pp   <= '0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    pp   <= t[W:1];
                    qreg <= {t[0], qreg[W-1:1]};
                    if (cnt == CNT_LAST) begin
                        // Capture the post-row {pp, qreg} directly, so the
                        // product is ready in the DONE cycle.
                        product <= {t[W:1], t[0], qreg[W-1:1]};
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mant_mul_seq.sv
// Bench for mant_mul_seq (W = 24).
// Uses directed table vectors, randomized operands checked against an
// arithmetic model, and hand-written sequences for the start-while-busy,
// back-to-back and reset-abort cases.
module tb_mant_mul_seq;

  localparam int W = 24;
  localparam int LAT = W + 1;  // edges from the start edge to the done edge, inclusive
  localparam int PERIOD = W + 2;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             start = 1'b0;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;

  mant_mul_seq #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain unsigned multiplication
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    longint unsigned r;
    r = longint'(x) * longint'(y);
    return r[2*W-1:0];
  endfunction

  // Driver task. It pulses start with operands va/vb and waits, with a
  // bound, for done. If inj_at is nonzero, it applies a start pulse with
  // operands ia/ib at that cycle of the run.
  // lat = edges from the start edge to the done edge, inclusive.
  // bcnt = busy cycles.
  task automatic run_mul(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input int inj_at, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         output logic [2*W-1:0] p, output int lat, output int bcnt);
    logic found;
    found = 1'b0;
    a = va; b = vb; start = 1'b1;
    lat = 0; bcnt = 0; p = '0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      start = 1'b0;
      if (inj_at != 0 && lat == inj_at) begin
        a = ia; b = ib; start = 1'b1;
      end
      if (done) begin
        p = product;
        found = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("done_seen", {63'd0, found}, 64'd1);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("idle_after_done", {63'd0, busy}, 64'd0);
    chk("product_held", product, p);
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [2*W-1:0] p;
    int lat, bcnt;
    logic [W-1:0] ra, rb;
    int last_done;
    int done_seen;
    logic found;

    vecs[0] = '{a: 24'd3,       b: 24'd5,       p: 48'h00000000000F};
    vecs[1] = '{a: 24'hCCCCCC,  b: 24'hAAAAAA,  p: 48'h888887777778};
    vecs[2] = '{a: 24'hFFFFFF,  b: 24'hFFFFFF,  p: 48'hFFFFFE000001};
    vecs[3] = '{a: 24'h800000,  b: 24'h800000,  p: 48'h400000000000};
    vecs[4] = '{a: 24'h000000,  b: 24'hFFFFFF,  p: 48'h000000000000};

    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_product", product, 64'd0);

    // Directed table
    foreach (vecs[i]) begin
      run_mul(vecs[i].a, vecs[i].b, 0, '0, '0, p, lat, bcnt);
      chk($sformatf("vec%0d_product", i), p, vecs[i].p);
      chk($sformatf("vec%0d_latency", i), lat, LAT);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, LAT);
    end

    // start pulse with new operands at cycle 10 is ignored
    run_mul(24'h123456, 24'h00ABCD, 10, 24'hFFFFFF, 24'hFFFFFF, p, lat, bcnt);
    chk("ignore_start_product", p, model(24'h123456, 24'h00ABCD));
    chk("ignore_start_latency", lat, LAT);
    @(negedge clk);
    chk("ignore_start_not_queued", {63'd0, busy}, 64'd0);

    // Randomized operands against the model
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom_range(0, 32'hFFFFFF));
      rb = W'($urandom_range(0, 32'hFFFFFF));
      exp_q.push_back(model(ra, rb));
      run_mul(ra, rb, 0, '0, '0, p, lat, bcnt);
      chk($sformatf("rand%0d_product", i), p, exp_q.pop_front());
    end

    // start held high: back-to-back results every W+2 cycles
    ra = W'($urandom); rb = W'($urandom);
    a = ra; b = rb; start = 1'b1;
    exp_q.push_back(model(ra, rb));
    last_done = 0;
    for (int r = 0; r < 3; r++) begin
      found = 1'b0;
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        if (done) begin
          found = 1'b1;
          break;
        end
      end
      chk($sformatf("b2b%0d_done_seen", r), {63'd0, found}, 64'd1);
      chk($sformatf("b2b%0d_product", r), product, exp_q.pop_front());
      if (r > 0) chk($sformatf("b2b%0d_interval", r), cyc - last_done, PERIOD);
      last_done = cyc;
      ra = W'($urandom); rb = W'($urandom);
      a = ra; b = rb;
      exp_q.push_back(model(ra, rb));
    end
    start = 1'b0;
    exp_q.delete();
    // Let the multiply already accepted finish, then return to idle
    for (int k = 0; k < 60 && busy; k++) @(negedge clk);
    @(negedge clk);
    chk("b2b_drained", {63'd0, busy}, 64'd0);

    // Reset during row 12 aborts the multiply
    a = 24'hABCDEF; b = 24'h654321; start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_abort_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_product", product, 64'd0);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);

    // Reset and start at the same edge: reset wins
    a = 24'd5; b = 24'd5; start = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    chk("rst_vs_start_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("rst_vs_start_still_idle", {63'd0, busy}, 64'd0);

    // First multiply after the abort
    run_mul(24'd7, 24'd9, 0, '0, '0, p, lat, bcnt);
    chk("post_abort_product", p, 64'd63);
    chk("post_abort_latency", lat, LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
